// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline stage: valid/ready handshake with a 2-entry skid buffer, sync flush and occupancy.
// Optional stall-cycle counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_skid_stage #(
    parameter int PC_W    = 32,
    parameter int REG_W   = 32,
    parameter int RADDR_W = 5,
    parameter int CMD_W   = 6,
    parameter int IMM_W   = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               flush_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [REG_W-1:0]   reg1_in,
    input  logic [REG_W-1:0]   reg2_in,
    input  logic [RADDR_W-1:0] rsd_in,
    input  logic               wr_rsd_in,
    input  logic [CMD_W-1:0]   cmdtype_in,
    input  logic [IMM_W-1:0]   imm_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [REG_W-1:0]   reg1_out,
    output logic [REG_W-1:0]   reg2_out,
    output logic [RADDR_W-1:0] rsd_out,
    output logic               wr_rsd_out,
    output logic [CMD_W-1:0]   cmdtype_out,
    output logic [IMM_W-1:0]   imm_out,
    output logic [1:0]         occupancy
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int P_W = PC_W + 2 * REG_W + RADDR_W + 1 + CMD_W + IMM_W;

    // State encoding equals the number of held entries, so it doubles as the occupancy/debug view.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [P_W-1:0] main_q, main_d;
    logic [P_W-1:0] skid_q, skid_d;
    logic [P_W-1:0] in_pl;
    logic           main_wr;
    logic           accept;
    logic           retire;

    // Handshake: a beat transfers on a cycle where valid && ready at the rising edge; valid never
    // waits on ready, and in_ready depends only on registered state (never on out_ready).
    assign in_pl     = {pc_in, reg1_in, reg2_in, rsd_in, wr_rsd_in, cmdtype_in, imm_in};
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;
    assign occupancy = state_q;

    assign {pc_out, reg1_out, reg2_out, rsd_out, main_wr, cmdtype_out, imm_out} = main_q;
    assign wr_rsd_out = main_wr && out_valid;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_in) begin
            // Cleared payload doubles as a NOP bubble (cmdtype 0).
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_pl;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_d = in_pl;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_pl;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Saturating count of cycles EX held back a valid entry; flush deliberately leaves it alone.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed self-checking bench for id_ex_skid_stage (covers stall_cnt when ID_EX_STALL_CNT_EN is defined).
module tb_id_ex_skid_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] reg1_in;
    logic [31:0] reg2_in;
    logic [4:0]  rsd_in;
    logic        wr_rsd_in;
    logic [5:0]  cmdtype_in;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] reg1_out;
    logic [31:0] reg2_out;
    logic [4:0]  rsd_out;
    logic        wr_rsd_out;
    logic [5:0]  cmdtype_out;
    logic [31:0] imm_out;
    logic [1:0]  occupancy;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_ex_skid_stage dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (flush_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_in       (pc_in),
        .reg1_in     (reg1_in),
        .reg2_in     (reg2_in),
        .rsd_in      (rsd_in),
        .wr_rsd_in   (wr_rsd_in),
        .cmdtype_in  (cmdtype_in),
        .imm_in      (imm_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_out      (pc_out),
        .reg1_out    (reg1_out),
        .reg2_out    (reg2_out),
        .rsd_out     (rsd_out),
        .wr_rsd_out  (wr_rsd_out),
        .cmdtype_out (cmdtype_out),
        .imm_out     (imm_out),
        .occupancy   (occupancy)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk_in = ~clk_in;

    // Driver: the other payload fields are fixed functions of pc so pass-through can be checked.
    task automatic drive(input logic v, input logic [31:0] pc, input logic wr,
                         input logic [4:0] rsd, input logic [5:0] cmd);
        in_valid   = v;
        pc_in      = pc;
        reg1_in    = pc + 32'h1000_0000;
        reg2_in    = ~pc;
        imm_in     = pc << 4;
        wr_rsd_in  = wr;
        rsd_in     = rsd;
        cmdtype_in = cmd;
    endtask

    // Advance one edge and sample 1 unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in    = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_wr_rsd", {31'd0, wr_rsd_out}, 32'd0);
        @(posedge clk_in);
        #4 rst_in = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 5'd1, 6'd1);
        tick();
        chk("str0_valid", {31'd0, out_valid}, 32'd1);
        chk("str0_pc", pc_out, 32'h0);
        chk("str0_occ", {30'd0, occupancy}, 32'd1);
        drive(1'b1, 32'h4, 1'b0, 5'd2, 6'd1);
        tick();
        chk("str1_pc", pc_out, 32'h4);
        chk("str1_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h8, 1'b0, 5'd3, 6'd1);
        tick();
        chk("str2_pc", pc_out, 32'h8);
        chk("str2_reg1", reg1_out, 32'h1000_0008);
        chk("str2_reg2", reg2_out, 32'hFFFF_FFF7);
        chk("str2_imm", imm_out, 32'h80);
        chk("str2_rsd", {27'd0, rsd_out}, 32'd3);
        drive(1'b1, 32'hC, 1'b0, 5'd4, 6'd1);
        tick();
        chk("str3_pc", pc_out, 32'hC);
        chk("str3_occ", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        tick();
        chk("str_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("str_drain_hold_pc", pc_out, 32'hC);
        chk("str_drain_occ", {30'd0, occupancy}, 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 5'd1, 6'd2);
        tick();
        chk("bp0_occ", {30'd0, occupancy}, 32'd1);
        chk("bp0_pc", pc_out, 32'h100);
        drive(1'b1, 32'h104, 1'b0, 5'd2, 6'd2);
        tick();
        chk("bp1_occ", {30'd0, occupancy}, 32'd2);
        chk("bp1_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h108, 1'b0, 5'd3, 6'd2);
        tick();
        chk("bp2_occ", {30'd0, occupancy}, 32'd2);
        chk("bp2_pc", pc_out, 32'h100);
        out_ready = 1'b1;
        tick();
        chk("bp3_pc", pc_out, 32'h104);
        chk("bp3_occ", {30'd0, occupancy}, 32'd1);
        chk("bp3_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp4_pc", pc_out, 32'h108);
        chk("bp4_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        tick();
        chk("bp5_occ", {30'd0, occupancy}, 32'd0);

        // Flush while full; incoming beat must be dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 1'b1, 5'd9, 6'd3);
        tick();
        drive(1'b1, 32'h304, 1'b1, 5'd10, 6'd3);
        tick();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        flush_in = 1'b1;
        drive(1'b1, 32'h200, 1'b1, 5'd11, 6'd5);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_cmd", {26'd0, cmdtype_out}, 32'd0);
        chk("fl_wr", {31'd0, wr_rsd_out}, 32'd0);
        chk("fl_pc", pc_out, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        // Flush from EMPTY with in_ready=1 still drops the beat
        tick();
        chk("fl_empty_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_empty_pc", pc_out, 32'd0);
        flush_in = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        tick();
        chk("fl_after_valid", {31'd0, out_valid}, 32'd0);

        // Write-enable gating
        drive(1'b1, 32'h400, 1'b1, 5'd7, 6'd4);
        tick();
        chk("we_valid", {31'd0, out_valid}, 32'd1);
        chk("we_wr", {31'd0, wr_rsd_out}, 32'd1);
        chk("we_rsd", {27'd0, rsd_out}, 32'd7);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        out_ready = 1'b1;
        tick();
        chk("we_idle_wr", {31'd0, wr_rsd_out}, 32'd0);
        chk("we_idle_rsd", {27'd0, rsd_out}, 32'd7);

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 1'b1, 5'd12, 6'd6);
        tick();
        drive(1'b1, 32'h504, 1'b1, 5'd13, 6'd6);
        tick();
        chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        #2 rst_in = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_pc", pc_out, 32'd0);
        chk("ar_rsd", {27'd0, rsd_out}, 32'd0);
        chk("ar_cmd", {26'd0, cmdtype_out}, 32'd0);
        #1 rst_in = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 5'd1, 6'd1);
        tick();
        chk("ar_first_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_first_pc", pc_out, 32'h40);

`ifdef ID_EX_STALL_CNT_EN
        // Stall counter: 10 stalled cycles, flush keeps the count, reset clears it
        drive(1'b0, 32'h0, 1'b0, 5'd0, 6'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sc_ten", {16'd0, stall_cnt}, 32'd10);
        out_ready = 1'b1;
        flush_in  = 1'b1;
        tick();
        flush_in = 1'b0;
        tick();
        chk("sc_after_flush", {16'd0, stall_cnt}, 32'd10);
        #2 rst_in = 1'b0;
        #1;
        chk("sc_after_reset", {16'd0, stall_cnt}, 32'd0);
        #1 rst_in = 1'b1;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised successor to the fixed ID→EX pipeline latch.
- Carries the decoded-instruction payload (pc, rs1/rs2 values, rd address, write-enable, command type, immediate) from ID to EX.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush for branch mispredict, and an occupancy output.
- Sits between the decoder and the execute unit. Stalls propagate by ready, not by a global stall wire.

Parameters:
- PC_W, 32, width of pc field
- REG_W, 32, width of reg1/reg2 operand fields
- RADDR_W, 5, width of destination register address
- CMD_W, 6, width of command-type field
- IMM_W, 32, width of immediate field

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- flush_in  in  1  synchronous flush, kills all held and incoming entries
- in_valid  in  1  ID presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- pc_in  in  PC_W  instruction pc
- reg1_in  in  REG_W  rs1 value
- reg2_in  in  REG_W  rs2 value
- rsd_in  in  RADDR_W  rd address
- wr_rsd_in  in  1  rd write enable
- cmdtype_in  in  CMD_W  command type
- imm_in  in  IMM_W  immediate
- out_valid  out  1  main entry valid toward EX
- out_ready  in  1  EX accepts this cycle
- pc_out, reg1_out, reg2_out, rsd_out, cmdtype_out, imm_out  out  same widths as the inputs  main-entry payload
- wr_rsd_out  out  1  main-entry write enable AND out_valid
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each payload plus a valid bit.
- Handshake events: accept = in_valid && in_ready; retire = out_valid && out_ready.
- States (occupancy):
  - EMPTY (0): accept → ONE, main<=in.
  - ONE (1):
    - accept and retire → ONE, main<=in.
    - accept only → TWO, skid<=in.
    - retire only → EMPTY.
    - neither → hold.
  - TWO (2): in_ready=0, so no accept.
    - retire → ONE, main<=skid, skid invalid.
    - otherwise hold.
- Latency: accept in cycle N → out_valid in cycle N+1 when the stage was empty or retiring.
- Throughput: 1 instruction/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry never bypasses main.
- Back-pressure: in_ready falls the cycle after the skid fills. One extra beat is absorbed, so in_ready has no combinational path from out_ready.
- flush_in=1 overrides everything:
  - Next state EMPTY; incoming beat dropped; retire that cycle is still seen by EX.
  - Main and skid payload fields cleared to 0 (cmdtype 0 = NOP bubble).
- Payload while out_valid=0: holds last value (cleared after flush or reset). wr_rsd_out is forced 0.
- Reset (rst_in=0, asynchronous):
  - out_valid=0, occupancy=0, in_ready=1.
  - All payload outputs 0; wr_rsd_out=0.
  - Reset mid-transfer discards both entries.
- No wrap-around or arithmetic on payload. Fields pass through bit-exact.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles with out_valid && !out_ready.
  - Saturates at 16'hFFFF; cleared by reset only, not by flush.
- Undefined: port absent, no counter logic.

Test Plan:
- Streaming: in_valid=1, out_ready=1, pc 0x0,0x4,0x8,0xC on consecutive cycles → out_valid every cycle from cycle 1, pc_out 0x0,0x4,0x8,0xC one cycle later, occupancy stays 1, in_ready stays 1.
- Back-pressure: stream pc 0x100,0x104,0x108 with out_ready=0 from cycle 1.
  - occupancy 1→2; in_ready=0 after 0x104 is accepted; 0x108 held by ID.
  - Raise out_ready → pc_out 0x100, then 0x104, then 0x108, none lost or duplicated.
- Flush in TWO state: occupancy=2, flush_in=1 with in_valid=1 pc 0x200.
  - Next cycle: out_valid=0, occupancy=0, cmdtype_out=0, wr_rsd_out=0; 0x200 never appears.
- Write-enable gating: accept wr_rsd_in=1 rsd_in=5'd7, retire, then idle → wr_rsd_out=1 only in the valid cycle, 0 afterwards while rsd_out stays 7.
- Async reset mid-operation: occupancy=2, drop rst_in between clock edges → out_valid=0, in_ready=1, all payload 0 immediately; after release, the first accept of pc 0x40 appears at pc_out next cycle.
- With ID_EX_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles → stall_cnt=10; flush → stall_cnt still 10; reset → 0.
